// File: rtl/flac_pkg.sv
// Shared types and constants for the FLAC fixed-predictor subframe decoder.
package flac_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WARM,
        S_METH,
        S_PORD,
        S_PARAM,
        S_UNARY,
        S_REM,
        S_ESCN,
        S_ESCS,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] RES_RICE4 = 2'b00;
    localparam logic [1:0] RES_RICE5 = 2'b01;
    localparam logic [3:0] ESC4      = 4'hF;
    localparam logic [4:0] ESC5      = 5'h1F;
    localparam int         MAX_ORDER = 4;

endpackage

// File: rtl/flac_rice_bit_decoder.sv
// Bit-serial Rice residual decoder: unary quotient, param-bit remainder, zigzag unfold.
// oRdone/oResidual are combinational in the cycle the residual's last bit is consumed.
module flac_rice_bit_decoder #(
    parameter int ACC_W = 20,
    parameter int QMAX  = 64
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iClear,
    input  logic [4:0]              iParam,
    input  logic                    iBit,
    input  logic                    iValid,
    input  logic                    iRem,
    output logic signed [ACC_W-1:0] oResidual,
    output logic                    oRdone,
    output logic                    oQerr
);
    localparam int UW = ACC_W + 2;
    localparam int QW = $clog2(QMAX + 1);

    logic [QW-1:0] r_q;
    logic [UW-1:0] r_r;
    logic [4:0]    r_rcnt;
    logic [UW-1:0] w_r_n;
    logic [UW-1:0] w_u;
    logic [UW-1:0] w_z;

    always_comb begin
        w_r_n  = {r_r[UW-2:0], iBit};
        oRdone = 1'b0;
        oQerr  = 1'b0;
        w_u    = '0;
        if (iValid) begin
            if (!iRem) begin
                if (!iBit) begin
                    oQerr = (r_q == QW'(QMAX));
                end else if (iParam == 5'd0) begin
                    oRdone = 1'b1;
                    w_u    = UW'(r_q);
                end
            end else if (r_rcnt == iParam - 5'd1) begin
                oRdone = 1'b1;
                w_u    = (UW'(r_q) << iParam) | w_r_n;
            end
        end
    end

    // Zigzag: even codes are non-negative, odd codes negative.
    assign w_z       = (w_u >> 1) ^ {UW{w_u[0]}};
    assign oResidual = $signed(w_z[ACC_W-1:0]);

    always_ff @(posedge iClock) begin
        if (!iReset || iClear || oRdone) begin
            r_q    <= '0;
            r_r    <= '0;
            r_rcnt <= '0;
        end else if (iValid) begin
            if (!iRem) begin
                if (!iBit && !oQerr) r_q <= r_q + 1'b1;
            end else begin
                r_r    <= w_r_n;
                r_rcnt <= r_rcnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/fixed_subframe_decoder_p.sv
// FLAC SUBFRAME_FIXED decoder (order 0..4): warm-up, residual partitions, prediction.
// Define FIXED_ESCAPE_EN to decode escape partitions; otherwise an escape code is an error.
module fixed_subframe_decoder_p
    import flac_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int BLOCK_W  = 16,
    parameter int QMAX     = 64
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iStart,
    input  logic [4:0]          iBps,
    input  logic [2:0]          iOrder,
    input  logic [BLOCK_W-1:0]  iBlockSize,
    input  logic                iData,
    input  logic                iValid,
    output logic                oReady,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oValid,
    output logic                oDone,
    output logic                oError,
    output state_t              oDbgState
);
    localparam int ACC_W = SAMPLE_W + 4;

    state_t                     r_state, w_state_n;
    logic [4:0]                 r_bps, r_bitcnt, r_param;
    logic [2:0]                 r_order, r_warm_cnt;
    logic [BLOCK_W-1:0]         r_bs, r_samp_left;
    logic                       r_method;
    logic [3:0]                 r_porder;
    logic [15:0]                r_part_idx;
    logic [ACC_W-1:0]           r_shift;
    logic signed [SAMPLE_W-1:0] r_s1, r_s2, r_s3, r_s4;
    logic [SAMPLE_W-1:0]        r_sample;
    logic                       r_valid, r_done, r_error;
`ifdef FIXED_ESCAPE_EN
    logic [4:0]                 r_escn;
`endif

    logic                       w_take, w_last, w_cfg_bad;
    logic [ACC_W-1:0]           w_shift_n;
    logic [4:0]                 w_param_val;
    logic                       w_is_esc, w_last_part, w_pord_bad;
    logic [3:0]                 w_pord_val;
    logic [BLOCK_W-1:0]         w_pord_mask, w_part_size;
    logic                       w_rice_valid, w_rdone, w_qerr;
    logic signed [ACC_W-1:0]    w_rres;
    logic                       w_err_set, w_emit, w_emit_warm, w_res_end, w_part_adv, w_load_part;
    logic signed [ACC_W-1:0]    w_res, w_pred, w_new;
    logic signed [ACC_W-1:0]    w_s1, w_s2, w_s3, w_s4;

    function automatic logic signed [ACC_W-1:0] sext(input logic [ACC_W-1:0] v, input logic [4:0] n);
        logic [ACC_W-1:0] t;
        t = v;
        if (n != 5'd0 && int'(n) < ACC_W) begin
            t = v << (ACC_W - int'(n));
            t = $signed(t) >>> (ACC_W - int'(n));
        end
        return $signed(t);
    endfunction

    assign w_cfg_bad   = (int'(iOrder) > MAX_ORDER) || (iBps == 5'd0) || (int'(iBps) > SAMPLE_W);
    assign w_shift_n   = {r_shift[ACC_W-2:0], iData};
    assign w_take      = oReady && iValid && !iStart;
    assign w_param_val = r_method ? w_shift_n[4:0] : {1'b0, w_shift_n[3:0]};
    assign w_is_esc    = r_method ? (w_shift_n[4:0] == ESC5) : (w_shift_n[3:0] == ESC4);
    assign w_last_part = (r_part_idx == ((16'd1 << r_porder) - 16'd1));
    assign w_part_size = (r_bs >> r_porder) - ((r_part_idx == 16'd0) ? BLOCK_W'(r_order) : '0);
    assign w_pord_val  = w_shift_n[3:0];
    assign w_pord_mask = (BLOCK_W'(1) << w_pord_val) - BLOCK_W'(1);
    assign w_pord_bad  = ((r_bs & w_pord_mask) != '0) || ((r_bs >> w_pord_val) < BLOCK_W'(r_order));
    assign w_rice_valid = w_take && (r_state == S_UNARY || r_state == S_REM);

    flac_rice_bit_decoder #(.ACC_W(ACC_W), .QMAX(QMAX)) u_rice (
        .iClock    (iClock),
        .iReset    (iReset),
        .iClear    (iStart),
        .iParam    (r_param),
        .iBit      (iData),
        .iValid    (w_rice_valid),
        .iRem      (r_state == S_REM),
        .oResidual (w_rres),
        .oRdone    (w_rdone),
        .oQerr     (w_qerr)
    );

    always_comb begin
        oReady = 1'b0;
        w_last = 1'b1;
        case (r_state)
            S_WARM:  begin oReady = 1'b1; w_last = (r_bitcnt == r_bps - 5'd1); end
            S_METH:  begin oReady = 1'b1; w_last = (r_bitcnt == 5'd1); end
            S_PORD:  begin oReady = 1'b1; w_last = (r_bitcnt == 5'd3); end
            S_PARAM: begin oReady = 1'b1; w_last = (r_bitcnt == (r_method ? 5'd4 : 5'd3)); end
            S_UNARY, S_REM: oReady = 1'b1;
`ifdef FIXED_ESCAPE_EN
            S_ESCN:  begin oReady = 1'b1; w_last = (r_bitcnt == 5'd4); end
            S_ESCS:  begin oReady = (r_escn != 5'd0); w_last = (r_bitcnt == r_escn - 5'd1); end
`endif
            default: ;
        endcase
    end

    // Next state plus one-cycle strobes for the datapath.
    always_comb begin
        w_state_n   = r_state;
        w_err_set   = 1'b0;
        w_emit      = 1'b0;
        w_emit_warm = 1'b0;
        w_res_end   = 1'b0;
        w_part_adv  = 1'b0;
        w_load_part = 1'b0;
        w_res       = '0;
        if (iStart) begin
            w_state_n = w_cfg_bad ? S_ERR : ((iOrder == 3'd0) ? S_METH : S_WARM);
        end else begin
            case (r_state)
                S_WARM: if (w_take && w_last) begin
                    w_emit      = 1'b1;
                    w_emit_warm = 1'b1;
                    if (r_warm_cnt == r_order - 3'd1) w_state_n = S_METH;
                end
                S_METH: if (w_take && w_last) begin
                    if (w_shift_n[1:0] == RES_RICE4 || w_shift_n[1:0] == RES_RICE5) w_state_n = S_PORD;
                    else begin w_state_n = S_ERR; w_err_set = 1'b1; end
                end
                S_PORD: if (w_take && w_last) begin
                    if (w_pord_bad) begin w_state_n = S_ERR; w_err_set = 1'b1; end
                    else w_state_n = S_PARAM;
                end
                S_PARAM: if (w_take && w_last) begin
                    if (w_part_size == '0) begin
                        if (w_last_part) w_state_n = S_DONE;
                        else w_part_adv = 1'b1;
                    end else if (w_is_esc) begin
`ifdef FIXED_ESCAPE_EN
                        w_load_part = 1'b1;
                        w_state_n   = S_ESCN;
`else
                        w_state_n = S_ERR;
                        w_err_set = 1'b1;
`endif
                    end else begin
                        w_load_part = 1'b1;
                        w_state_n   = S_UNARY;
                    end
                end
                S_UNARY: if (w_take) begin
                    if (w_qerr) begin
                        w_state_n = S_ERR;
                        w_err_set = 1'b1;
                    end else if (iData) begin
                        if (r_param == 5'd0) begin w_res_end = 1'b1; w_res = w_rres; end
                        else w_state_n = S_REM;
                    end
                end
                S_REM: if (w_take && w_rdone) begin
                    w_res_end = 1'b1;
                    w_res     = w_rres;
                    w_state_n = S_UNARY;
                end
`ifdef FIXED_ESCAPE_EN
                S_ESCN: if (w_take && w_last) w_state_n = S_ESCS;
                S_ESCS: begin
                    // A zero width means every residual in the partition is 0 and no bits follow.
                    if (r_escn == 5'd0) w_res_end = 1'b1;
                    else if (w_take && w_last) begin
                        w_res_end = 1'b1;
                        w_res     = sext(w_shift_n, r_escn);
                    end
                end
`endif
                S_DONE:  w_state_n = S_IDLE;
                default: ;
            endcase
            if (w_res_end) begin
                w_emit = 1'b1;
                if (r_samp_left == BLOCK_W'(1)) begin
                    if (w_last_part) w_state_n = S_DONE;
                    else begin w_part_adv = 1'b1; w_state_n = S_PARAM; end
                end
            end
        end
    end

    assign w_s1 = {{4{r_s1[SAMPLE_W-1]}}, r_s1};
    assign w_s2 = {{4{r_s2[SAMPLE_W-1]}}, r_s2};
    assign w_s3 = {{4{r_s3[SAMPLE_W-1]}}, r_s3};
    assign w_s4 = {{4{r_s4[SAMPLE_W-1]}}, r_s4};

    always_comb begin
        case (r_order)
            3'd1:    w_pred = w_s1;
            3'd2:    w_pred = (w_s1 <<< 1) - w_s2;
            3'd3:    w_pred = (w_s1 <<< 1) + w_s1 - (w_s2 <<< 1) - w_s2 + w_s3;
            3'd4:    w_pred = (w_s1 <<< 2) - (w_s2 <<< 2) - (w_s2 <<< 1) + (w_s3 <<< 2) - w_s4;
            default: w_pred = '0;
        endcase
        w_new = w_emit_warm ? sext(w_shift_n, r_bps) : (w_pred + w_res);
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            r_state     <= S_IDLE;
            r_bps       <= '0;
            r_order     <= '0;
            r_bs        <= '0;
            r_bitcnt    <= '0;
            r_warm_cnt  <= '0;
            r_method    <= 1'b0;
            r_porder    <= '0;
            r_part_idx  <= '0;
            r_samp_left <= '0;
            r_param     <= '0;
            r_shift     <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_s4        <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef FIXED_ESCAPE_EN
            r_escn      <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_valid <= w_emit;
            r_done  <= (r_state == S_DONE) && !iStart;
            if (w_emit) begin
                r_sample <= w_new[SAMPLE_W-1:0];
                r_s1     <= w_new[SAMPLE_W-1:0];
                r_s2     <= r_s1;
                r_s3     <= r_s2;
                r_s4     <= r_s3;
            end
            if (iStart) begin
                r_bps       <= iBps;
                r_order     <= iOrder;
                r_bs        <= iBlockSize;
                r_bitcnt    <= '0;
                r_warm_cnt  <= '0;
                r_method    <= 1'b0;
                r_porder    <= '0;
                r_part_idx  <= '0;
                r_samp_left <= '0;
                r_param     <= '0;
                r_error     <= w_cfg_bad;
            end else begin
                if (w_err_set) r_error <= 1'b1;
                if (w_take) begin
                    r_shift  <= w_shift_n;
                    r_bitcnt <= w_last ? 5'd0 : r_bitcnt + 5'd1;
                end
                if (w_emit_warm) r_warm_cnt <= r_warm_cnt + 3'd1;
                if (r_state == S_METH && w_take && w_last) r_method <= w_shift_n[0];
                if (r_state == S_PORD && w_take && w_last) begin
                    r_porder   <= w_pord_val;
                    r_part_idx <= '0;
                end
                if (r_state == S_PARAM && w_take && w_last) r_param <= w_param_val;
`ifdef FIXED_ESCAPE_EN
                if (r_state == S_ESCN && w_take && w_last) r_escn <= w_shift_n[4:0];
`endif
                if (w_load_part) r_samp_left <= w_part_size;
                else if (w_res_end) r_samp_left <= r_samp_left - BLOCK_W'(1);
                if (w_part_adv) r_part_idx <= r_part_idx + 16'd1;
            end
        end
    end

    assign oSample   = r_sample;
    assign oValid    = r_valid;
    assign oDone     = r_done;
    assign oError    = r_error;
    assign oDbgState = r_state;

endmodule
